// File: rtl/mseq_pkg.sv
// Shared types and constants for the microsequencer.
package mseq_pkg;

    localparam int unsigned MSEQ_ADDR_W = 8;
    localparam int unsigned MSEQ_WORD_W = 16;
    // Control-word bit that ends a routine when MSEQ_END_BIT_EN is defined.
    localparam int unsigned END_BIT     = 15;

    typedef enum logic [1:0] {
        MSEQ_IDLE,
        MSEQ_RUN,
        MSEQ_FIN
    } mseq_state_e;

endpackage

// File: rtl/mseq_sequencer.sv
// Microsequencer: fetches `len` consecutive control words from a ROM with a
// one-cycle registered read and issues them to the datapath under ready/valid
// back-pressure. Optional feature macro: MSEQ_END_BIT_EN (a word with END_BIT
// set ends the routine early when accepted).
module mseq_sequencer
    import mseq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MSEQ_ADDR_W-1:0] entry_addr,
    input  logic [MSEQ_ADDR_W-1:0] len,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   rom_en,
    output logic [MSEQ_ADDR_W-1:0] rom_addr,
    input  logic [MSEQ_WORD_W-1:0] rom_data,
    output logic [MSEQ_WORD_W-1:0] ctrl_word,
    output logic                   ctrl_valid,
    input  logic                   ctrl_ready
);

    mseq_state_e            state_q, state_d;
    logic [MSEQ_ADDR_W-1:0] upc_q, upc_d;
    logic [MSEQ_ADDR_W-1:0] remaining_q, remaining_d;
    // ROM output register holds a word not yet taken by the datapath.
    logic                   rv_q, rv_d;

    logic accept;
    logic end_hit;

    assign accept = rv_q & ctrl_ready;

`ifdef MSEQ_END_BIT_EN
    assign end_hit = accept & rom_data[END_BIT];
`else
    assign end_hit = 1'b0;
`endif

    // Next-state, fetch and completion logic.
    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        remaining_d = remaining_q;
        rv_d        = rv_q;
        rom_en      = 1'b0;
        done        = 1'b0;

        case (state_q)
            MSEQ_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        upc_d       = entry_addr;
                        remaining_d = len;
                        state_d     = MSEQ_RUN;
                    end else begin
                        state_d = MSEQ_FIN;
                    end
                end
            end
            MSEQ_RUN: begin
                if (abort) begin
                    rv_d    = 1'b0;
                    state_d = MSEQ_IDLE;
                end else if (end_hit) begin
                    // Early end: any word still in the ROM register is dropped.
                    rv_d    = 1'b0;
                    state_d = MSEQ_FIN;
                end else begin
                    // Fetch whenever the ROM register is free or being emptied now,
                    // so a released stall costs no bubble.
                    rom_en = (remaining_q != '0) && (!rv_q || ctrl_ready);
                    if (rom_en) begin
                        upc_d       = upc_q + 8'd1;
                        remaining_d = remaining_q - 8'd1;
                        rv_d        = 1'b1;
                    end else if (ctrl_ready) begin
                        rv_d = 1'b0;
                        if (accept && remaining_q == '0) begin
                            state_d = MSEQ_FIN;
                        end
                    end
                end
            end
            MSEQ_FIN: begin
                rv_d    = 1'b0;
                done    = !abort;
                state_d = MSEQ_IDLE;
            end
            default: begin
                rv_d    = 1'b0;
                state_d = MSEQ_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MSEQ_IDLE;
            upc_q       <= '0;
            remaining_q <= '0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            remaining_q <= remaining_d;
            rv_q        <= rv_d;
        end
    end

    assign busy       = (state_q != MSEQ_IDLE);
    assign rom_addr   = upc_q;
    assign ctrl_word  = rom_data;
    assign ctrl_valid = rv_q;

endmodule

// File: tb/tb_mseq_sequencer.sv
// Directed self-checking bench for mseq_sequencer with a registered ROM model.
module tb_mseq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  entry_addr;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic        ctrl_ready;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle snapshot of one routine, indexed by cycle number (cycle 0 = start).
    logic        en_log    [16];
    logic [7:0]  addr_log  [16];
    logic [15:0] word_log  [16];
    logic        valid_log [16];
    logic        busy_log  [16];
    logic        done_log  [16];
    int          done_cnt;
    int          en_cnt;

    mseq_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .entry_addr (entry_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready)
    );

    always #5 clk = ~clk;

    // Control ROM: registered read, output held while rom_en is low.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs ncyc cycles starting at posedge+1; start is high in cycle 0.
    task automatic run(input logic [7:0] ea, input logic [7:0] ln, input int st_lo,
                       input int st_hi, input int ab_cyc, input int ncyc);
        done_cnt = 0;
        en_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            en_log[i] = 1'b0; addr_log[i] = 8'h00; word_log[i] = 16'h0000;
            valid_log[i] = 1'b0; busy_log[i] = 1'b0; done_log[i] = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            start      = (c == 0);
            entry_addr = ea;
            len        = ln;
            ctrl_ready = !(c >= st_lo && c <= st_hi);
            abort      = (c == ab_cyc);
            @(negedge clk);
            en_log[c]    = rom_en;
            addr_log[c]  = rom_addr;
            word_log[c]  = ctrl_word;
            valid_log[c] = ctrl_valid;
            busy_log[c]  = busy;
            done_log[c]  = done;
            done_cnt     += int'(done);
            en_cnt       += int'(rom_en);
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        abort      = 1'b0;
        ctrl_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h03] = 16'h0008; mem[8'h04] = 16'h0004;
        mem[8'h05] = 16'h0002; mem[8'h06] = 16'h0010;
        mem[8'hFE] = 16'h00FE; mem[8'hFF] = 16'h00FF; mem[8'h00] = 16'h0100;
        mem[8'h20] = 16'h0011; mem[8'h21] = 16'h8000; mem[8'h22] = 16'h0033;
        mem[8'h23] = 16'h0044; mem[8'h24] = 16'h0055;

        rst = 1'b1; start = 1'b0; abort = 1'b0; ctrl_ready = 1'b1;
        entry_addr = 8'h00; len = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 8'h00);
        check("rst_valid", ctrl_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset asserted for 2 cycles mid-routine
        run(8'h03, 8'd4, -1, -1, -1, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_valid", ctrl_valid, 0);
        check("mrst_rom_en", rom_en, 0);
        check("mrst_rom_addr", rom_addr, 8'h00);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("mrst_no_done", done_cnt, 0);
        @(posedge clk); #1;

        // Basic 4-word routine, no stalls
        run(8'h03, 8'd4, -1, -1, -1, 9);
        check("basic_busy_c0", busy_log[0], 0);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("basic_en_c%0d", c), en_log[c], 1);
            check($sformatf("basic_addr_c%0d", c), addr_log[c], 8'h03 + c[7:0] - 8'h01);
        end
        check("basic_en_c5", en_log[5], 0);
        check("basic_valid_c1", valid_log[1], 0);
        check("basic_word_c2", word_log[2], 16'h0008);
        check("basic_word_c3", word_log[3], 16'h0004);
        check("basic_word_c4", word_log[4], 16'h0002);
        check("basic_word_c5", word_log[5], 16'h0010);
        check("basic_valid_c5", valid_log[5], 1);
        check("basic_valid_c6", valid_log[6], 0);
        check("basic_done_c6", done_log[6], 1);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_busy_c7", busy_log[7], 0);

        // Same routine, ready low in cycles 3-4
        run(8'h03, 8'd4, 3, 4, -1, 10);
        check("stall_en_c3", en_log[3], 0);
        check("stall_en_c4", en_log[4], 0);
        check("stall_word_c3", word_log[3], 16'h0004);
        check("stall_word_c4", word_log[4], 16'h0004);
        check("stall_valid_c4", valid_log[4], 1);
        check("stall_en_c5", en_log[5], 1);
        check("stall_addr_c5", addr_log[5], 8'h05);
        check("stall_word_c6", word_log[6], 16'h0002);
        check("stall_word_c7", word_log[7], 16'h0010);
        check("stall_done_c7", done_log[7], 0);
        check("stall_done_c8", done_log[8], 1);
        check("stall_done_cnt", done_cnt, 1);

        // Address wrap at 0xFF
        run(8'hFE, 8'd3, -1, -1, -1, 7);
        check("wrap_addr_c1", addr_log[1], 8'hFE);
        check("wrap_addr_c2", addr_log[2], 8'hFF);
        check("wrap_addr_c3", addr_log[3], 8'h00);
        check("wrap_word_c4", word_log[4], 16'h0100);
        check("wrap_done_c5", done_log[5], 1);
        check("wrap_en_cnt", en_cnt, 3);

        // Abort in cycle 3 of a 4-word run
        run(8'h03, 8'd4, -1, -1, 3, 9);
        check("abort_valid_c3", valid_log[3], 1);
        check("abort_valid_c4", valid_log[4], 0);
        check("abort_busy_c4", busy_log[4], 0);
        check("abort_en_c4", en_log[4], 0);
        check("abort_done_cnt", done_cnt, 0);

        // Empty routine
        run(8'h10, 8'd0, -1, -1, -1, 4);
        check("len0_busy_c1", busy_log[1], 1);
        check("len0_done_c1", done_log[1], 1);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_en_cnt", en_cnt, 0);
        check("len0_busy_c2", busy_log[2], 0);

        // Word with bit 15 set at offset 1 of a 5-word routine
        run(8'h20, 8'd5, -1, -1, -1, 10);
        check("endb_word_c3", word_log[3], 16'h8000);
`ifdef MSEQ_END_BIT_EN
        check("endb_done_c4", done_log[4], 1);
        check("endb_valid_c4", valid_log[4], 0);
        check("endb_busy_c5", busy_log[5], 0);
`else
        check("endb_done_c4", done_log[4], 0);
        check("endb_word_c6", word_log[6], 16'h0055);
        check("endb_done_c7", done_log[7], 1);
`endif
        check("endb_done_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
